tick_bcd_counter: RTL and testbench
===================================

TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_in (legal 2..4).
REQ-002 Parameter MODULUS, default 60, count modulus (legal 2..100); the count runs 0..MODULUS-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 tick_in  input  1  slow square wave from the upstream clock divider, treated as asynchronous.
REQ-007 start  input  1  level; request to enter or resume counting.
REQ-008 stop  input  1  level; request to pause counting.
REQ-009 clear  input  1  level; request to zero the count and return to IDLE.
REQ-010 tick_pulse  output  1  registered one-cycle pulse per synchronized rising edge of tick_in.
REQ-011 ones  output  4  BCD units digit of the count.
REQ-012 tens  output  4  BCD tens digit of the count.
REQ-013 carry  output  1  registered one-cycle pulse on wrap from MODULUS-1 to 0.
REQ-014 running  output  1  high only while in state RUN.

Function
REQ-015 tick_in SHALL pass through a chain of SYNC_STAGES flops, then one history flop; tick_pulse <= last_sync & ~history.
REQ-016 With SYNC_STAGES=2, tick_pulse SHALL be high in the cycle after the 3rd rising clk_in edge that samples tick_in high, for exactly one cycle.
REQ-017 tick_in high for any number of cycles SHALL produce exactly one tick_pulse; falling edges produce none.
REQ-018 States: IDLE, RUN, HOLD; running = (state == RUN).
REQ-019 Transition priority per cycle: clear > stop > start.
REQ-020 clear in any state -> IDLE, ones=0, tens=0, carry=0 on the next edge.
REQ-021 IDLE + start -> RUN; IDLE + stop -> stays IDLE.
REQ-022 RUN + stop -> HOLD; RUN + start alone -> stays RUN.
REQ-023 HOLD + start -> RUN; count retained unchanged in HOLD.
REQ-024 Count SHALL advance on the edge where tick_pulse is high and the registered state is RUN; new digits are visible the following cycle.
REQ-025 A tick_pulse coincident with stop while in RUN SHALL still be counted; one coincident with start while in IDLE/HOLD SHALL NOT be counted.
REQ-026 A tick_pulse coincident with clear SHALL NOT be counted; clear wins.
REQ-027 Increment: ones 9 -> 0 with tens+1; otherwise ones+1.
REQ-028 When the count equals MODULUS-1 and increments, ones and tens SHALL both become 0 and carry SHALL be high for that one following cycle only.
REQ-029 ones SHALL never exceed 9, and 10*tens+ones SHALL never reach MODULUS.

Reset
REQ-030 While rst is sampled high: state=IDLE, all synchronizer and history flops=0, tick_pulse=0, ones=0, tens=0, carry=0, running=0.
REQ-031 rst SHALL override clear/start/stop and any in-flight tick; a tick_in edge whose synchronization straddles reset release SHALL produce at most one tick_pulse.

Verification
REQ-032 rst 2 cycles, tick_in=1 held, no start -> tick_pulse single pulse at cycle 3 after release; ones=0, running=0.
REQ-033 start, 5 tick_in rising edges -> running=1, ones=5, tens=0, carry never high.
REQ-034 MODULUS=60, run 60 ticks from 0 -> 59 then 00 with carry high exactly 1 cycle; ones never shows 10..15.
REQ-035 Count to 7, stop, 3 ticks, start, 1 tick -> 7 held during HOLD, then 8; stop coincident with a tick_pulse counts that tick.
REQ-036 Count to 23, assert clear and start together with a tick_pulse -> IDLE, 00, running=0, no carry.
REQ-037 Assert rst mid-RUN at count 42 -> next cycle all outputs 0, state IDLE; after release, count restarts only after start.

Source files
------------

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD counter advanced by synchronized rising edges of an asynchronous tick,
// with an IDLE/RUN/HOLD control FSM (clear > stop > start).
module tick_bcd_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MODULUS     = 60
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic       tick_pulse,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       running
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [3:0] LAST_ONES = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] LAST_TENS = 4'((MODULUS - 1) / 10);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   tick_pulse_q, tick_pulse_d;
    state_t                 state_q, state_d;
    logic [3:0]             ones_q, ones_d;
    logic [3:0]             tens_q, tens_d;
    logic                   carry_q, carry_d;
    logic                   running_q, running_d;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], tick_in};
        hist_d       = sync_q[SYNC_STAGES-1];
        tick_pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;

        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else if (stop) begin
            if (state_q == RUN)
                state_d = HOLD;
        end else if (start)
            state_d = RUN;

        // The count follows the registered state, so a start arriving with a pulse is not counted
        ones_d  = ones_q;
        tens_d  = tens_q;
        carry_d = 1'b0;
        if (clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (tick_pulse_q && state_q == RUN) begin
            if (ones_q == LAST_ONES && tens_q == LAST_TENS) begin
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                carry_d = 1'b1;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            tick_pulse_q <= 1'b0;
            state_q      <= IDLE;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            carry_q      <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            tick_pulse_q <= tick_pulse_d;
            state_q      <= state_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            carry_q      <= carry_d;
            running_q    <= running_d;
        end
    end

    assign tick_pulse = tick_pulse_q;
    assign ones       = ones_q;
    assign tens       = tens_q;
    assign carry      = carry_q;
    assign running    = running_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: integer-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control/tick traffic.
module tb_tick_bcd_counter;
    localparam int S = 2;
    localparam int M = 60;

    logic clk_in = 1'b0;
    logic rst = 1'b1, tick_in = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic tick_pulse, carry, running;
    logic [3:0] ones, tens;

    tick_bcd_counter #(.SYNC_STAGES(S), .MODULUS(M)) dut (
        .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
        .clear(clear), .tick_pulse(tick_pulse), .ones(ones), .tens(tens),
        .carry(carry), .running(running)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: tick_in sample history, integer count, state 0=IDLE 1=RUN 2=HOLD
    logic [7:0] hist;
    logic       exp_pulse, exp_carry;
    int         exp_count, exp_state;

    always @(posedge clk_in) begin
        if (rst) begin
            hist <= '0; exp_pulse <= 1'b0; exp_count <= 0; exp_state <= 0; exp_carry <= 1'b0;
        end else begin
            hist      <= {hist[6:0], tick_in};
            exp_pulse <= hist[S-1] & ~hist[S];
            exp_state <= clear ? 0 : stop ? (exp_state == 0 ? 0 : 2) : start ? 1 : exp_state;
            exp_count <= clear ? 0 : (exp_pulse && exp_state == 1) ? (exp_count + 1) % M : exp_count;
            exp_carry <= !clear && exp_pulse && exp_state == 1 && exp_count == M - 1;
        end
    end

    int tests = 0, fails = 0, carry_seen = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_in);
            chk("m_pulse",   {7'd0, tick_pulse}, {7'd0, exp_pulse});
            chk("m_ones",    {4'd0, ones},       8'(exp_count % 10));
            chk("m_tens",    {4'd0, tens},       8'(exp_count / 10));
            chk("m_carry",   {7'd0, carry},      {7'd0, exp_carry});
            chk("m_running", {7'd0, running},    {7'd0, exp_state == 1});
            if (carry === 1'b1) carry_seen++;
        end
    endtask

    task automatic tick();
        tick_in = 1'b1; cyc(4);
        tick_in = 1'b0; cyc(4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // tick whose pulse coincides with the given control levels for one cycle
    task automatic tick_with(input logic c, input logic sp, input logic st);
        tick_in = 1'b1; cyc(3);
        clear = c; stop = sp; start = st; cyc(1);
        clear = 1'b0; stop = 1'b0; start = 1'b0; cyc(0);
        tick_in = 1'b0; cyc(4);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    initial begin
        // reset with tick held high: one pulse on the third edge after release
        tick_in = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1); chk("r32_pulse_c1", {7'd0, tick_pulse}, 8'd0);
        cyc(1); chk("r32_pulse_c2", {7'd0, tick_pulse}, 8'd0);
        cyc(1); chk("r32_pulse_c3", {7'd0, tick_pulse}, 8'd1);
        cyc(1); chk("r32_pulse_c4", {7'd0, tick_pulse}, 8'd0);
        chk("r32_ones", {4'd0, ones}, 8'd0);
        chk("r32_running", {7'd0, running}, 8'd0);
        cyc(6); chk("r32_no_repulse", {7'd0, tick_pulse}, 8'd0);
        tick_in = 1'b0; cyc(4);

        // start then five ticks
        carry_seen = 0;
        pulse_start();
        ticks(5);
        chk("r33_running", {7'd0, running}, 8'd1);
        chk("r33_ones", {4'd0, ones}, 8'd5);
        chk("r33_tens", {4'd0, tens}, 8'd0);
        chk("r33_no_carry", 8'(carry_seen), 8'd0);

        // run to 59, then wrap
        ticks(54);
        chk("r34_ones59", {4'd0, ones}, 8'd9);
        chk("r34_tens59", {4'd0, tens}, 8'd5);
        chk("r34_no_carry_yet", 8'(carry_seen), 8'd0);
        tick();
        chk("r34_wrap_ones", {4'd0, ones}, 8'd0);
        chk("r34_wrap_tens", {4'd0, tens}, 8'd0);
        chk("r34_carry_once", 8'(carry_seen), 8'd1);

        // count to 7, stop with a coincident pulse, hold, resume
        ticks(7);
        chk("r35_seven", {4'd0, ones}, 8'd7);
        tick_with(1'b0, 1'b1, 1'b0);
        chk("r35_stop_counted", {4'd0, ones}, 8'd8);
        chk("r35_hold_running", {7'd0, running}, 8'd0);
        ticks(3);
        chk("r35_held", {4'd0, ones}, 8'd8);
        pulse_start();
        tick();
        chk("r35_resumed", {4'd0, ones}, 8'd9);
        chk("r35_running", {7'd0, running}, 8'd1);

        // clear, count to 23, clear+start on a pulse
        clear = 1'b1; cyc(1); clear = 1'b0;
        pulse_start();
        ticks(23);
        chk("r36_ones23", {4'd0, ones}, 8'd3);
        chk("r36_tens23", {4'd0, tens}, 8'd2);
        carry_seen = 0;
        tick_with(1'b1, 1'b0, 1'b1);
        chk("r36_ones", {4'd0, ones}, 8'd0);
        chk("r36_tens", {4'd0, tens}, 8'd0);
        chk("r36_running", {7'd0, running}, 8'd0);
        chk("r36_no_carry", 8'(carry_seen), 8'd0);

        // reset mid-run at 42
        pulse_start();
        ticks(42);
        chk("r37_ones42", {4'd0, ones}, 8'd2);
        chk("r37_tens42", {4'd0, tens}, 8'd4);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("r37_rst_ones", {4'd0, ones}, 8'd0);
        chk("r37_rst_tens", {4'd0, tens}, 8'd0);
        chk("r37_rst_running", {7'd0, running}, 8'd0);
        ticks(2);
        chk("r37_idle_ones", {4'd0, ones}, 8'd0);
        pulse_start();
        tick();
        chk("r37_restart", {4'd0, ones}, 8'd1);

        // randomized traffic, including resets that straddle tick edges
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) tick_in = ~tick_in;
            start = ($urandom_range(19) == 0);
            stop  = ($urandom_range(29) == 0);
            clear = ($urandom_range(79) == 0);
            rst   = ($urandom_range(249) == 0);
            cyc(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
